// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and width constants shared by the ALU and its bench
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

endpackage

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - 32-bit parallel-prefix carry-lookahead adder with signed overflow
module alu_adder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] prop;
  logic [DATA_W-1:0] grp_g;
  logic [DATA_W-1:0] grp_p;
  logic [DATA_W-1:0] nxt_g;
  logic [DATA_W-1:0] nxt_p;
  logic [DATA_W-1:0] carry;

  // Kogge-Stone prefix: after five doubling levels grp_g[i]/grp_p[i] span bits i..0
  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    grp_g = gen;
    grp_p = prop;
    nxt_g = gen;
    nxt_p = prop;
    for (int lvl = 0; lvl < 5; lvl++) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = (1 << lvl); i < DATA_W; i++) begin
        nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
        nxt_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
    carry = {grp_g[DATA_W-2:0] | (grp_p[DATA_W-2:0] & {(DATA_W-1){cin}}), cin};
  end

  assign sum      = prop ^ carry;
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle 32-bit ALU with registered result and compare/overflow flags
module alu
  import alu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic [4:0]        ctrl_ALUopcode,
  input  logic [4:0]        ctrl_shiftamt,
  output logic [DATA_W-1:0] data_result,
  output logic              isNotEqual,
  output logic              isLessThan,
  output logic              overflow
);

  logic              is_sub;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;
  logic [DATA_W-1:0] sll_val;
  logic [DATA_W-1:0] sra_val;

  logic [DATA_W-1:0] result_d, result_q;
  logic              ne_d, ne_q;
  logic              lt_d, lt_q;
  logic              ovf_d, ovf_q;

  // One adder serves both ADD and SUB; SUB feeds ~B with carry-in 1
  assign is_sub = (ctrl_ALUopcode == OP_SUB);
  assign add_b  = is_sub ? ~data_operandB : data_operandB;

  alu_adder u_adder (
    .a        (data_operandA),
    .b        (add_b),
    .cin      (is_sub),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    sll_val = data_operandA;
    sra_val = data_operandA;
    for (int s = 0; s < 5; s++) begin
      if (ctrl_shiftamt[s]) begin
        sll_val = sll_val << (1 << s);
        sra_val = DATA_W'($signed(sra_val) >>> (1 << s));
      end
    end
  end

  // Comparison flags track A-B every cycle; these forms equal |(A-B) and diff[31]^ovf
  assign ne_d = (data_operandA != data_operandB);
  assign lt_d = ($signed(data_operandA) < $signed(data_operandB));

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD, OP_SUB: begin
        result_d = add_sum;
        ovf_d    = add_ovf;
      end
      OP_AND:  result_d = data_operandA & data_operandB;
      OP_OR:   result_d = data_operandA | data_operandB;
      OP_SLL:  result_d = sll_val;
      OP_SRA:  result_d = sra_val;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for the registered ALU
module tb_alu;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [4:0]  ctrl_ALUopcode = '0;
  logic [4:0]  ctrl_shiftamt = '0;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;

  typedef struct {
    logic [31:0] r;
    logic        ne;
    logic        lt;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  alu dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference built from 33-bit sign-extended arithmetic and native operators
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] o, input logic [4:0] s);
    exp_t e;
    logic [32:0] se;
    logic [32:0] de;
    se = {x[31], x} + {y[31], y};
    de = {x[31], x} - {y[31], y};
    e.ne = (x != y);
    e.lt = ($signed(x) < $signed(y));
    e.r  = '0;
    e.ov = 1'b0;
    case (o)
      5'd0: begin e.r = se[31:0]; e.ov = se[32] ^ se[31]; end
      5'd1: begin e.r = de[31:0]; e.ov = de[32] ^ de[31]; end
      5'd2: e.r = x & y;
      5'd3: e.r = x | y;
      5'd4: e.r = x << s;
      5'd5: e.r = 32'($signed(x) >>> s);
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] o, input logic [4:0] s);
    data_operandA  = x;
    data_operandB  = y;
    ctrl_ALUopcode = o;
    ctrl_shiftamt  = s;
    sb.push_back(model(x, y, o, s));
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd3;
    ctrl_ALUopcode = OP_ADD;
    ctrl_shiftamt = 5'd0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      checks++;
      if ({data_result, isNotEqual, isLessThan, overflow} !== 35'd0) begin
        failures++;
        $display("FAIL reset_cycle%0d outputs got=%h exp=0", c,
                 {data_result, isNotEqual, isLessThan, overflow});
      end
    end
    reset = 1'b0;
    drive(32'd5, 32'd3, OP_ADD, 5'd0);
    @(posedge clock); #1;
    e = sb.pop_front();
    checks += 2;
    if (data_result !== 32'd8 || data_result !== e.r) begin
      failures++;
      $display("FAIL reset_release result got=%h exp=%h", data_result, e.r);
    end
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_release overflow got=%b exp=0", overflow);
    end
  endtask

  task automatic test_add_sub();
    exp_t e;
    logic [31:0] va[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd5, 32'h8000_0000};
    logic [31:0] vb[5] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1};
    logic [4:0]  vo[5] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
    for (int i = 0; i < 5; i++) begin
      drive(va[i], vb[i], vo[i], 5'd0);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks += 4;
      if (data_result !== e.r) begin failures++; $display("FAIL addsub%0d result got=%h exp=%h", i, data_result, e.r); end
      if (overflow !== e.ov) begin failures++; $display("FAIL addsub%0d overflow got=%b exp=%b", i, overflow, e.ov); end
      if (isNotEqual !== e.ne) begin failures++; $display("FAIL addsub%0d isNotEqual got=%b exp=%b", i, isNotEqual, e.ne); end
      if (isLessThan !== e.lt) begin failures++; $display("FAIL addsub%0d isLessThan got=%b exp=%b", i, isLessThan, e.lt); end
    end
  endtask

  task automatic test_logic_shift();
    exp_t e;
    logic [31:0] va[6] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h0000_0001, 32'h8000_0000, 32'h8765_4321, 32'h1234_5678};
    logic [31:0] vb[6] = '{32'hFF00_FF00, 32'hFF00_FF00, 32'hDEAD_BEEF, 32'h0, 32'h5, 32'hFFFF_FFFF};
    logic [4:0]  vo[6] = '{OP_AND, OP_OR, OP_SLL, OP_SRA, OP_SRA, OP_SLL};
    logic [4:0]  vs[6] = '{5'd9, 5'd3, 5'd31, 5'd4, 5'd0, 5'd0};
    logic [31:0] lit[6] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h8000_0000, 32'hF800_0000, 32'h8765_4321, 32'h1234_5678};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vo[i], vs[i]);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks += 3;
      if (data_result !== lit[i]) begin failures++; $display("FAIL logsh%0d result got=%h exp=%h", i, data_result, lit[i]); end
      if (data_result !== e.r) begin failures++; $display("FAIL logsh%0d model got=%h exp=%h", i, data_result, e.r); end
      if (overflow !== 1'b0) begin failures++; $display("FAIL logsh%0d overflow got=%b exp=0", i, overflow); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    logic [31:0] va[8] = '{32'd1, 32'd10, 32'hAAAA_5555, 32'h0F0F_0000, 32'h0000_00F1, 32'hC000_0010, 32'h7FFF_FFFF, 32'd9};
    logic [31:0] vb[8] = '{32'd2, 32'd3, 32'hFFFF_0000, 32'h0000_F0F0, 32'd0, 32'd0, 32'd1, 32'd9};
    logic [4:0]  vo[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA, 5'd7, OP_SUB};
    logic [4:0]  vs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd2, 5'd5, 5'd0};
    n = 0;
    drive(va[0], vb[0], vo[0], vs[0]);
    for (int i = 0; i < 8 + 24; i++) begin
      @(posedge clock); #1;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b2b%0d scoreboard empty got=0 exp=1", i);
      end else begin
        e = sb.pop_front();
        checks += 4;
        if (data_result !== e.r) begin failures++; $display("FAIL b2b%0d result got=%h exp=%h", i, data_result, e.r); end
        if (overflow !== e.ov) begin failures++; $display("FAIL b2b%0d overflow got=%b exp=%b", i, overflow, e.ov); end
        if (isNotEqual !== e.ne) begin failures++; $display("FAIL b2b%0d isNotEqual got=%b exp=%b", i, isNotEqual, e.ne); end
        if (isLessThan !== e.lt) begin failures++; $display("FAIL b2b%0d isLessThan got=%b exp=%b", i, isLessThan, e.lt); end
      end
      if (i + 1 < 8) begin
        drive(va[i+1], vb[i+1], vo[i+1], vs[i+1]);
      end else if (i + 1 < 32) begin
        drive($urandom, (n % 3 == 0) ? data_operandA : $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        n++;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain scoreboard left got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
